// File: rtl/pico_instr_streamer.sv
// Host-side streamer: FIFO-buffered 16-bit instructions sent as LO/HI load beats plus an execute gap.
// Optional STREAMER_BIT7_CHECK_EN: words with inst[7]=1 are consumed but never enqueued.
module pico_instr_streamer #(
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [15:0]                   in_instr,
    input  logic                          hold_i,
    output logic                          load_en_o,
    output logic [6:0]                    load_lo_o,
    output logic [7:0]                    load_hi_o,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          bit7_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, LO, HI, GAP} state_t;

    // Bit 7 never reaches the wire, so only 15 bits are stored.
    logic [14:0]   mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          full;
    logic          empty;
    logic          accept;
    logic          push;
    logic          pop;
    logic          can_pop;
    logic [14:0]   head_word;

    state_t        state;
    state_t        state_n;
    logic [GW-1:0] gap_cnt;
    logic [GW-1:0] gap_n;
    logic [7:0]    head_hi;
    logic          en_n;
    logic [6:0]    lo_n;
    logic [7:0]    hi_n;

    assign full       = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty      = (wr_ptr == rd_ptr);
    assign in_ready   = !full;
    assign accept     = in_valid && in_ready;
`ifdef STREAMER_BIT7_CHECK_EN
    assign push       = accept && !in_instr[7];
`else
    assign push       = accept;
`endif
    assign fifo_count = wr_ptr - rd_ptr;
    assign busy       = (state != IDLE) || !empty;
    assign can_pop    = !empty && !hold_i;
    assign head_word  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= {in_instr[15:8], in_instr[6:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            bit7_err <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (accept && in_instr[7])
                bit7_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gap_cnt   <= '0;
            head_hi   <= '0;
            load_en_o <= 1'b0;
            load_lo_o <= '0;
            load_hi_o <= '0;
        end else begin
            state     <= state_n;
            gap_cnt   <= gap_n;
            load_en_o <= en_n;
            load_lo_o <= lo_n;
            load_hi_o <= hi_n;
            if (pop)
                head_hi <= head_word[14:7];
        end
    end

    always_comb begin
        state_n = state;
        gap_n   = gap_cnt;
        en_n    = 1'b0;
        lo_n    = load_lo_o;
        hi_n    = load_hi_o;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (can_pop) begin
                    pop     = 1'b1;
                    state_n = LO;
                end
            end
            LO: begin
                en_n    = 1'b1;
                hi_n    = head_hi;
                state_n = HI;
            end
            HI: begin
                gap_n   = GW'(GAP_CYCLES - 1);
                state_n = GAP;
            end
            GAP: begin
                if (gap_cnt != '0) begin
                    gap_n = gap_cnt - 1'b1;
                end else if (can_pop) begin
                    pop     = 1'b1;
                    state_n = LO;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        // A pop launches the LO beat on the very next cycle.
        if (pop) begin
            en_n = 1'b1;
            lo_n = head_word[6:0];
            hi_n = '0;
        end
    end
endmodule

// File: tb/tb_pico_instr_streamer.sv
// Bench for pico_instr_streamer: directed scenarios plus random traffic against a queue model.
module tb_pico_instr_streamer;
    localparam int DEPTH = 4;
    localparam int G     = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_instr = '0;
    logic        hold_i = 1'b0;
    logic        load_en_o;
    logic [6:0]  load_lo_o;
    logic [7:0]  load_hi_o;
    logic        busy;
    logic [2:0]  fifo_count;
    logic        bit7_err;

    pico_instr_streamer #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(G)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .hold_i(hold_i),
        .load_en_o(load_en_o), .load_lo_o(load_lo_o), .load_hi_o(load_hi_o),
        .busy(busy), .fifo_count(fifo_count), .bit7_err(bit7_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: queue of pending words, plus the edge index of the last pop.
    logic [15:0] q[$];
    int          n = 0;
    int          last_pop = -1000;
    bit          active = 0;
    logic [15:0] cur = '0;
    logic [6:0]  elo = '0;
    logic [7:0]  ehi = '0;
    bit          eerr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, n);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [15:0] ins, input logic h);
        bit canpop;
        bit rdy;
        int ph;
        bit een;
        bit ebusy;
        rst = r; in_valid = v; in_instr = ins; hold_i = h;
        @(posedge clk);
        n++;
        if (r) begin
            q.delete(); active = 0; elo = '0; ehi = '0; eerr = 0;
        end else begin
            canpop = !active || (n - last_pop >= G + 2);
            rdy    = q.size() < DEPTH;
            if (canpop && q.size() > 0 && !h) begin
                cur = q.pop_front();
                last_pop = n; active = 1;
                elo = cur[6:0]; ehi = '0;
            end else if (active && n - last_pop == 1) begin
                ehi = cur[15:8];
            end
            if (v && rdy) begin
                if (ins[7]) eerr = 1;
`ifdef STREAMER_BIT7_CHECK_EN
                if (!ins[7])
`endif
                q.push_back(ins);
            end
        end
        ph    = n - last_pop;
        een   = active && ph <= 1;
        ebusy = (active && ph <= G + 1) || q.size() > 0;
        #1;
        chk("load_en", load_en_o, een);
        chk("load_lo", load_lo_o, elo);
        chk("load_hi", load_hi_o, ehi);
        chk("busy", busy, ebusy);
        chk("fifo_count", fifo_count, q.size());
        chk("in_ready", in_ready, q.size() < DEPTH);
        chk("bit7_err", bit7_err, eerr);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    initial begin
        logic [15:0] w;
        step(1'b1, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b0, 16'h0, 1'b0);
        // Single word: LO 1C, HI A5, gap, then idle
        step(1'b0, 1'b1, 16'hA51C, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b0);
        chk("t1_lo", {load_en_o, load_lo_o}, {1'b1, 7'h1C});
        step(1'b0, 1'b0, 16'h0, 1'b0);
        chk("t1_hi", {load_en_o, load_hi_o}, {1'b1, 8'hA5});
        idle(3);
        chk("t1_busy", busy, 1'b0);
        // Burst of 4, then pushes against a full FIFO while pops drain it
        step(1'b0, 1'b1, 16'h1101, 1'b0);
        step(1'b0, 1'b1, 16'h2202, 1'b0);
        step(1'b0, 1'b1, 16'h3303, 1'b0);
        step(1'b0, 1'b1, 16'h4404, 1'b0);
        step(1'b0, 1'b1, 16'h5505, 1'b0);
        step(1'b0, 1'b1, 16'h6606, 1'b0);
        step(1'b0, 1'b1, 16'h7707, 1'b0);
        step(1'b0, 1'b1, 16'h0808, 1'b0);
        idle(18);
        // Hold during HI of word 1 with word 2 queued
        step(1'b0, 1'b1, 16'h1234, 1'b0);
        step(1'b0, 1'b1, 16'h5678, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 16'h0, 1'b1);
        chk("t3_held", load_en_o, 1'b0);
        idle(6);
        // Bit 7 word
        step(1'b0, 1'b1, 16'h0080, 1'b0);
        idle(5);
        chk("t4_err", bit7_err, 1'b1);
        // Reset during HI beat
        step(1'b0, 1'b1, 16'hBE3F, 1'b0);
        step(1'b0, 1'b1, 16'h0101, 1'b0);
        step(1'b0, 1'b1, 16'h0202, 1'b0);
        chk("t5_hi", load_hi_o, 8'hBE);
        step(1'b1, 1'b0, 16'h0, 1'b0);
        chk("t5_rst", {load_en_o, fifo_count, in_ready, bit7_err}, {1'b1 ^ 1'b1, 3'd0, 1'b1, 1'b0});
        idle(2);
        // Random traffic
        for (int i = 0; i < 600; i++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 9) != 0) w[7] = 1'b0;
            step($urandom_range(0, 149) == 0, $urandom_range(0, 9) < 7,
                 w, $urandom_range(0, 4) == 0);
        end
        idle(20);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
